// File: rtl/huffman_seq_ctrl.sv
// -----------------------------------------------------------------------------
// huffman_seq_ctrl
//
// Top-level sequencer for a 10-symbol Huffman encoding path.
//   1. LOAD  : accepts NSYM frequency words in symbol order (0..NSYM-1).
//   2. BUILD : pulses the tree builder and waits for Build_done (with timeout).
//   3. CODE  : pulses the code generator and waits for Code_done (with
//              timeout), then latches the whole code table.
//   4. READY : serves single-cycle symbol -> {len, code} lookups.
//   An ERROR state holds the error code until the next Cfg_go.
//
// Ports
//   Clk_in, n_Rst         clock (rising edge) / asynchronous active-low reset
//   Cfg_go, Abort         start/restart request, force return to IDLE
//   Freq_valid/_data      frequency stream in, Freq_ready accepts it
//   Freq_bus              stored frequencies, symbol 0 in the LSBs
//   Build_start/_done     tree builder handshake
//   Start_code/Code_done  code generator handshake (generator uses the
//                         falling edge of Start_code)
//   Code_bus              generator output table, Code0 in the LSBs
//   Enc_valid/_sym/_ready lookup request
//   Out_valid/_code/_len  lookup result strobe (one cycle, no backpressure)
//   Table_valid, Busy     status
//   Err                   00 none, 01 build timeout, 10 code timeout,
//                         11 all-zero frequencies
// -----------------------------------------------------------------------------
module huffman_seq_ctrl #(
    parameter int NSYM    = 10,
    parameter int FREQ_W  = 8,
    parameter int TIMEOUT = 255,
    parameter int CODE_W  = 13
) (
    input  logic                     Clk_in,
    input  logic                     n_Rst,
    input  logic                     Cfg_go,
    input  logic                     Abort,
    input  logic                     Freq_valid,
    input  logic [FREQ_W-1:0]        Freq_data,
    output logic                     Freq_ready,
    output logic [NSYM*FREQ_W-1:0]   Freq_bus,
    output logic                     Build_start,
    input  logic                     Build_done,
    output logic                     Start_code,
    input  logic                     Code_done,
    input  logic [NSYM*CODE_W-1:0]   Code_bus,
    input  logic                     Enc_valid,
    input  logic [3:0]               Enc_sym,
    output logic                     Enc_ready,
    output logic                     Out_valid,
    output logic [8:0]               Out_code,
    output logic [3:0]               Out_len,
    output logic                     Table_valid,
    output logic                     Busy,
    output logic [1:0]               Err
);

    localparam int CNT_W = $clog2(NSYM);
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    localparam logic [CNT_W-1:0] LAST_SYM = CNT_W'(NSYM - 1);
    localparam logic [3:0]       NSYM_4   = 4'(NSYM);
    // The counter is compared one short of TIMEOUT so the error state is
    // entered exactly TIMEOUT cycles after the start pulse.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_BUILD,
        S_CODE,
        S_READY,
        S_ERROR
    } state_t;

    state_t               state_reg;
    logic [CNT_W-1:0]     sym_cnt_reg;
    logic [TMO_W-1:0]     tmo_cnt_reg;
    logic                 nz_seen_reg;     // any nonzero frequency seen so far
    logic [1:0]           err_reg;
    logic                 build_start_reg;
    logic                 start_code_reg;
    logic                 out_valid_reg;
    logic [8:0]           out_code_reg;
    logic [3:0]           out_len_reg;
    logic [FREQ_W-1:0]    freq_reg [NSYM];
    logic [CODE_W-1:0]    tbl_reg  [NSYM];

    always_ff @(posedge Clk_in or negedge n_Rst) begin
        if (!n_Rst) begin
            state_reg       <= S_IDLE;
            sym_cnt_reg     <= '0;
            tmo_cnt_reg     <= '0;
            nz_seen_reg     <= 1'b0;
            err_reg         <= 2'b00;
            build_start_reg <= 1'b0;
            start_code_reg  <= 1'b0;
            out_valid_reg   <= 1'b0;
            out_code_reg    <= '0;
            out_len_reg     <= '0;
            for (int i = 0; i < NSYM; i++) begin
                freq_reg[i] <= '0;
                tbl_reg[i]  <= '0;
            end
        end else begin
            // Pulse outputs default low every cycle.
            build_start_reg <= 1'b0;
            start_code_reg  <= 1'b0;
            out_valid_reg   <= 1'b0;

            if (Abort) begin
                // Stored frequencies and table are kept; leaving READY makes
                // the table unusable and any pending result is dropped.
                state_reg <= S_IDLE;
                err_reg   <= 2'b00;
            end else begin
                // A lookup accepted in READY always returns its result, even
                // if Cfg_go leaves READY on the same edge.
                if (state_reg == S_READY && Enc_valid) begin
                    out_valid_reg <= 1'b1;
                    if (Enc_sym < NSYM_4) begin
                        out_code_reg <= tbl_reg[Enc_sym][8:0];
                        out_len_reg  <= tbl_reg[Enc_sym][12:9];
                    end else begin
                        out_code_reg <= '0;
                        out_len_reg  <= '0;
                    end
                end

                case (state_reg)
                    S_IDLE, S_READY, S_ERROR: begin
                        if (Cfg_go) begin
                            state_reg   <= S_LOAD;
                            err_reg     <= 2'b00;
                            sym_cnt_reg <= '0;
                            nz_seen_reg <= 1'b0;
                        end
                    end

                    S_LOAD: begin
                        if (Freq_valid) begin
                            freq_reg[sym_cnt_reg] <= Freq_data;
                            if (sym_cnt_reg == LAST_SYM) begin
                                if (nz_seen_reg || (Freq_data != '0)) begin
                                    state_reg       <= S_BUILD;
                                    build_start_reg <= 1'b1;
                                    tmo_cnt_reg     <= '0;
                                end else begin
                                    state_reg <= S_ERROR;
                                    err_reg   <= 2'b11;
                                end
                            end else begin
                                sym_cnt_reg <= sym_cnt_reg + 1'b1;
                                nz_seen_reg <= nz_seen_reg | (Freq_data != '0);
                            end
                        end
                    end

                    S_BUILD: begin
                        // Done has priority over a simultaneous timeout.
                        if (Build_done) begin
                            state_reg      <= S_CODE;
                            start_code_reg <= 1'b1;
                            tmo_cnt_reg    <= '0;
                        end else if (tmo_cnt_reg == TMO_LAST) begin
                            state_reg   <= S_ERROR;
                            err_reg     <= 2'b01;
                            tmo_cnt_reg <= TMO_MAX;
                        end else begin
                            tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
                        end
                    end

                    S_CODE: begin
                        if (Code_done) begin
                            state_reg <= S_READY;
                            for (int i = 0; i < NSYM; i++) begin
                                tbl_reg[i] <= Code_bus[i*CODE_W +: CODE_W];
                            end
                        end else if (tmo_cnt_reg == TMO_LAST) begin
                            state_reg   <= S_ERROR;
                            err_reg     <= 2'b10;
                            tmo_cnt_reg <= TMO_MAX;
                        end else begin
                            tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
                        end
                    end

                    default: state_reg <= S_IDLE;
                endcase
            end
        end
    end

    // Frequency slots exposed as one flat bus, symbol 0 in the LSBs.
    generate
        for (genvar gi = 0; gi < NSYM; gi++) begin : g_freq_bus
            assign Freq_bus[gi*FREQ_W +: FREQ_W] = freq_reg[gi];
        end
    endgenerate

    // Status outputs decode directly from the registered state.
    assign Freq_ready  = (state_reg == S_LOAD);
    assign Enc_ready   = (state_reg == S_READY);
    assign Table_valid = (state_reg == S_READY);
    assign Busy        = (state_reg == S_LOAD) || (state_reg == S_BUILD) ||
                         (state_reg == S_CODE);

    assign Build_start = build_start_reg;
    assign Start_code  = start_code_reg;
    assign Out_valid   = out_valid_reg;
    assign Out_code    = out_code_reg;
    assign Out_len     = out_len_reg;
    assign Err         = err_reg;

endmodule

// File: tb/tb_huffman_seq_ctrl.sv
module tb_huffman_seq_ctrl;

    localparam int NSYM    = 10;
    localparam int FREQ_W  = 8;
    localparam int TIMEOUT = 255;
    localparam int CODE_W  = 13;

    logic                   Clk_in;
    logic                   n_Rst;
    logic                   Cfg_go;
    logic                   Abort;
    logic                   Freq_valid;
    logic [FREQ_W-1:0]      Freq_data;
    logic                   Freq_ready;
    logic [NSYM*FREQ_W-1:0] Freq_bus;
    logic                   Build_start;
    logic                   Build_done;
    logic                   Start_code;
    logic                   Code_done;
    logic [NSYM*CODE_W-1:0] Code_bus;
    logic                   Enc_valid;
    logic [3:0]             Enc_sym;
    logic                   Enc_ready;
    logic                   Out_valid;
    logic [8:0]             Out_code;
    logic [3:0]             Out_len;
    logic                   Table_valid;
    logic                   Busy;
    logic [1:0]             Err;

    huffman_seq_ctrl #(
        .NSYM(NSYM), .FREQ_W(FREQ_W), .TIMEOUT(TIMEOUT), .CODE_W(CODE_W)
    ) dut (
        .Clk_in(Clk_in), .n_Rst(n_Rst), .Cfg_go(Cfg_go), .Abort(Abort),
        .Freq_valid(Freq_valid), .Freq_data(Freq_data), .Freq_ready(Freq_ready),
        .Freq_bus(Freq_bus), .Build_start(Build_start), .Build_done(Build_done),
        .Start_code(Start_code), .Code_done(Code_done), .Code_bus(Code_bus),
        .Enc_valid(Enc_valid), .Enc_sym(Enc_sym), .Enc_ready(Enc_ready),
        .Out_valid(Out_valid), .Out_code(Out_code), .Out_len(Out_len),
        .Table_valid(Table_valid), .Busy(Busy), .Err(Err)
    );

    initial Clk_in = 1'b0;
    always #5 Clk_in = ~Clk_in;

    // Reference model state: what was loaded and what the generator produced.
    logic [FREQ_W-1:0] ref_freq [NSYM];
    logic [3:0]        ref_len  [NSYM];
    logic [8:0]        ref_code [NSYM];

    typedef struct {
        int         sym;
        logic [3:0] len;
        logic [8:0] code;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    int n_checks     = 0;
    int n_pass       = 0;
    int build_pulses = 0;
    int code_pulses  = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h", name, act, req);
    endtask

    // Lookup semantics: in-range symbol returns its table entry, otherwise 0/0.
    function automatic exp_t model(input int sym);
        exp_t e;
        e.sym = sym;
        if (sym < NSYM) begin
            e.len  = ref_len[sym];
            e.code = ref_code[sym];
        end else begin
            e.len  = 4'd0;
            e.code = 9'd0;
        end
        return e;
    endfunction

    function automatic logic [NSYM*FREQ_W-1:0] pack_freq();
        logic [NSYM*FREQ_W-1:0] v;
        for (int i = 0; i < NSYM; i++) v[i*FREQ_W +: FREQ_W] = ref_freq[i];
        return v;
    endfunction

    function automatic logic [NSYM*CODE_W-1:0] pack_table();
        logic [NSYM*CODE_W-1:0] v;
        for (int i = 0; i < NSYM; i++) v[i*CODE_W +: CODE_W] = {ref_len[i], ref_code[i]};
        return v;
    endfunction

    // Monitor: counts start pulses and scores every lookup result.
    always @(negedge Clk_in) begin
        if (n_Rst) begin
            if (Build_start) build_pulses++;
            if (Start_code)  code_pulses++;
            if (Out_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_out actual=len%0d/code%03h required=no_result", Out_len, Out_code);
                end else begin
                    mon_e = exp_q.pop_front();
                    check($sformatf("lookup_sym%0d", mon_e.sym), {Out_len, Out_code}, {mon_e.len, mon_e.code});
                    $display("lookup sym=%0d len=%0d code=%03h exp_len=%0d exp_code=%03h",
                             mon_e.sym, Out_len, Out_code, mon_e.len, mon_e.code);
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge Clk_in);
        #1;
    endtask

    task automatic start_cfg();
        Cfg_go = 1'b1;
        step();
        Cfg_go = 1'b0;
    endtask

    task automatic rand_freqs();
        for (int i = 0; i < NSYM; i++) ref_freq[i] = FREQ_W'($urandom_range(0, 255));
        ref_freq[$urandom_range(0, NSYM-1)] = FREQ_W'($urandom_range(1, 255));
    endtask

    task automatic rand_table();
        for (int i = 0; i < NSYM; i++) begin
            ref_len[i]  = 4'($urandom_range(0, 9));
            ref_code[i] = 9'($urandom_range(0, 511));
        end
    endtask

    task automatic load_freqs(input bit gaps);
        for (int i = 0; i < NSYM; i++) begin
            if (gaps) begin
                Freq_valid = 1'b0;
                step();
            end
            if (i == NSYM-1) check("load_before_last", {Freq_ready, Busy, Build_start}, 3'b110);
            Freq_valid = 1'b1;
            Freq_data  = ref_freq[i];
            step();
        end
        Freq_valid = 1'b0;
    endtask

    // Entered on BUILD cycle 0; leaves on CODE cycle 0.
    task automatic run_build(input int dly);
        check("build_start_first_cycle", Build_start, 1'b1);
        repeat (dly) step();
        Build_done = 1'b1;
        step();
        Build_done = 1'b0;
        check("code_entry", {Start_code, Build_start, Busy}, 3'b101);
    endtask

    // Entered on CODE cycle 0; leaves in READY. The bus is scrambled afterwards
    // so lookups prove the table was latched.
    task automatic run_code(input int dly);
        Code_bus = pack_table();
        repeat (dly) step();
        Code_done = 1'b1;
        step();
        Code_done = 1'b0;
        Code_bus  = {$urandom, $urandom, $urandom, $urandom};
        check("ready_status", {Table_valid, Enc_ready, Busy, Err}, 5'b11000);
    endtask

    task automatic do_lookup(input int sym);
        Enc_valid = 1'b1;
        Enc_sym   = 4'(sym);
        exp_q.push_back(model(sym));
        step();
        Enc_valid = 1'b0;
    endtask

    task automatic drain_check();
        step();
        step();
        check("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    int bp0;
    int cp0;

    initial begin
        n_Rst = 1'b0; Cfg_go = 1'b0; Abort = 1'b0; Freq_valid = 1'b0; Freq_data = '0;
        Build_done = 1'b0; Code_done = 1'b0; Code_bus = '0; Enc_valid = 1'b0; Enc_sym = '0;
        #3;
        check("reset_outputs", {Busy, Err, Table_valid, Out_valid, Build_start, Start_code, Freq_ready, Enc_ready}, 9'd0);
        check("reset_freq_bus", Freq_bus, '0);
        step();
        n_Rst = 1'b1;
        step();

        // Nominal flow.
        ref_freq[0] = 8'd5;  ref_freq[1] = 8'd9;  ref_freq[2] = 8'd12; ref_freq[3] = 8'd13;
        ref_freq[4] = 8'd16; ref_freq[5] = 8'd45; ref_freq[6] = 8'd1;  ref_freq[7] = 8'd2;
        ref_freq[8] = 8'd3;  ref_freq[9] = 8'd4;
        rand_table();
        ref_len[0] = 4'd3; ref_code[0] = 9'h005;
        bp0 = build_pulses; cp0 = code_pulses;
        start_cfg();
        check("load_entry", {Freq_ready, Busy, Table_valid, Err}, 5'b11000);
        load_freqs(1'b0);
        check("nominal_freq_bus", Freq_bus, pack_freq());
        run_build(3);
        run_code(6);
        check("nominal_one_build_pulse", 32'(build_pulses - bp0), 32'd1);
        check("nominal_one_code_pulse", 32'(code_pulses - cp0), 32'd1);
        do_lookup(0);
        check("nominal_out_sym0", {Out_valid, Out_len, Out_code}, {1'b1, 4'd3, 9'h005});
        drain_check();

        // Back-to-back lookups 9, 3, 12.
        Enc_valid = 1'b1; Enc_sym = 4'd9; exp_q.push_back(model(9)); step();
        check("b2b_valid_1", Out_valid, 1'b1);
        Enc_sym = 4'd3; exp_q.push_back(model(3)); step();
        check("b2b_valid_2", Out_valid, 1'b1);
        Enc_sym = 4'd12; exp_q.push_back(model(12)); step();
        check("b2b_valid_3", {Out_valid, Out_len, Out_code}, {1'b1, 4'd0, 9'd0});
        Enc_valid = 1'b0;
        step();
        check("b2b_valid_end", Out_valid, 1'b0);

        // Cfg_go with a simultaneous lookup.
        Cfg_go = 1'b1; Enc_valid = 1'b1; Enc_sym = 4'd7; exp_q.push_back(model(7));
        step();
        Cfg_go = 1'b0; Enc_valid = 1'b0;
        check("cfg_lookup_result", {Out_valid, Table_valid, Freq_ready}, 3'b101);
        drain_check();
        // Cfg_go ignored in LOAD.
        Cfg_go = 1'b1; step(); Cfg_go = 1'b0;
        check("cfg_ignored_in_load", {Freq_ready, Busy}, 2'b11);

        // Handshake gaps (restart a fresh LOAD after an abort).
        Abort = 1'b1; step(); Abort = 1'b0;
        check("abort_from_load", {Busy, Freq_ready, Err}, 4'b0000);
        rand_freqs(); rand_table();
        start_cfg();
        load_freqs(1'b1);
        check("gaps_freq_bus", Freq_bus, pack_freq());
        run_build(0);
        run_code(2);
        for (int k = 0; k < 4; k++) do_lookup($urandom_range(0, 15));
        drain_check();

        // Build timeout, then restart.
        rand_freqs();
        start_cfg();
        load_freqs(1'b0);
        repeat (TIMEOUT-1) step();
        check("build_tmo_not_yet", {Err, Busy}, 3'b001);
        step();
        check("build_tmo", {Err, Busy}, 3'b010);
        step();
        check("build_tmo_hold", Err, 2'b01);
        start_cfg();
        check("restart_after_tmo", {Err, Busy, Freq_ready}, 4'b0011);

        // Code timeout.
        load_freqs(1'b0);
        run_build(1);
        repeat (TIMEOUT-1) step();
        check("code_tmo_not_yet", {Err, Busy}, 3'b001);
        step();
        check("code_tmo", {Err, Busy, Table_valid}, 4'b1000);

        // All-zero frequencies.
        for (int i = 0; i < NSYM; i++) ref_freq[i] = '0;
        bp0 = build_pulses;
        start_cfg();
        load_freqs(1'b0);
        check("zero_err", {Err, Busy, Build_start}, 4'b1100);
        step();
        check("zero_no_build_pulse", 32'(build_pulses - bp0), 32'd0);

        // Abort mid-BUILD; later Build_done ignored.
        rand_freqs();
        cp0 = code_pulses;
        start_cfg();
        load_freqs(1'b0);
        step();
        Abort = 1'b1; step(); Abort = 1'b0;
        check("abort_build_idle", {Busy, Err, Table_valid}, 4'b0000);
        Build_done = 1'b1; step(); Build_done = 1'b0; step();
        check("late_build_done_ignored", {Busy, Start_code, 32'(code_pulses - cp0)}, {2'b00, 32'd0});

        // Abort and Cfg_go together.
        Abort = 1'b1; Cfg_go = 1'b1; step(); Abort = 1'b0; Cfg_go = 1'b0;
        check("abort_beats_cfg", {Busy, Freq_ready}, 2'b00);

        // Randomized full flows.
        for (int it = 0; it < 6; it++) begin
            rand_freqs(); rand_table();
            start_cfg();
            load_freqs(1'($urandom_range(0, 1)));
            check($sformatf("rand%0d_freq_bus", it), Freq_bus, pack_freq());
            run_build($urandom_range(0, 10));
            run_code($urandom_range(0, 10));
            for (int k = 0; k < 8; k++) begin
                do_lookup($urandom_range(0, 15));
                if ($urandom_range(0, 2) == 0) step();
            end
            drain_check();
        end

        // Reset pulsed mid-CODE while Start_code is high.
        rand_freqs();
        start_cfg();
        load_freqs(1'b0);
        run_build(0);
        n_Rst = 1'b0;
        #2;
        check("async_reset_outputs", {Busy, Start_code, Err, Table_valid, Freq_ready, Out_valid}, 7'd0);
        check("async_reset_freq_bus", Freq_bus, '0);
        step();
        n_Rst = 1'b1;
        step();
        check("after_reset_idle", {Busy, Err}, 3'b000);

        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/huffman_seq_ctrl.md
Name: huffman_seq_ctrl

Overview:
- Top-level sequencer for the 10-symbol (0-9) Huffman path.
- Collects symbol frequencies and pulses the tree builder, then pulses the code generator (falling-edge start, 13-bit {len,code} entries).
- Latches the resulting code table and serves single-cycle symbol-to-code lookups.
- Guards each external phase with a timeout and reports errors.

Parameters:
NSYM, 10, number of symbols (fixed table depth)
FREQ_W, 8, frequency width per symbol
TIMEOUT, 255, max cycles waiting for Build_done / Code_done
CODE_W, 13, code-table entry width: [12:9] length, [8:0] code bits, right-aligned

Ports:
Clk_in  in  1  single clock, all logic on rising edge
n_Rst  in  1  asynchronous, active-low reset
Cfg_go  in  1  start/restart request (level sampled per cycle)
Abort  in  1  force return to IDLE
Freq_valid  in  1  frequency word valid
Freq_data  in  FREQ_W  frequency, symbols presented in order 0..NSYM-1
Freq_ready  out  1  frequency accepted when valid&ready
Freq_bus  out  NSYM*FREQ_W  stored frequencies, symbol 0 in LSBs
Build_start  out  1  one-cycle pulse to tree builder
Build_done  in  1  tree builder finished
Start_code  out  1  high exactly one cycle; generator triggers on its falling edge
Code_done  in  1  code generator finished
Code_bus  in  NSYM*CODE_W  generator outputs Code0..Code9, Code0 in LSBs
Enc_valid  in  1  lookup request
Enc_sym  in  4  symbol to encode
Enc_ready  out  1  lookup accepted
Out_valid  out  1  one-cycle result strobe
Out_code  out  9  code bits
Out_len  out  4  code length, 0 = no code
Table_valid  out  1  code table loaded and usable
Busy  out  1  high in LOAD/BUILD/CODE
Err  out  2  00 none, 01 build timeout, 10 code timeout, 11 all-zero frequencies

Behaviour:
- Reset (n_Rst low, async): state IDLE. All outputs 0, including Freq_bus, code table, symbol counter and timeout counter.
- States: IDLE, LOAD, BUILD, CODE, READY, ERROR.
- IDLE: Cfg_go=1 -> LOAD. On entry to LOAD: Err cleared, symbol counter=0, Table_valid=0.
- LOAD:
  - Freq_ready=1.
  - Each valid&ready handshake writes Freq_data into slot[counter] and increments the counter.
  - The handshake with counter=NSYM-1 moves to BUILD next cycle.
  - If all NSYM stored values are 0, go to ERROR with Err=11 instead.
- BUILD:
  - Build_start=1 on the first cycle in the state only. Timeout counter cleared on entry.
  - Build_done=1 -> CODE.
  - Counter reaching TIMEOUT without done -> ERROR, Err=01.
- CODE:
  - Start_code=1 on the first cycle only; the falling edge follows one cycle later. Timeout counter cleared on entry.
  - Code_done=1: latch all of Code_bus into the table -> READY.
  - Timeout -> ERROR, Err=10.
- Done and timeout on the same cycle: done wins.
- READY:
  - Table_valid=1, Enc_ready=1.
  - Enc_valid&Enc_ready with Enc_sym<NSYM: next cycle Out_valid=1, Out_code=entry[8:0], Out_len=entry[12:9].
  - Enc_sym>=NSYM: Out_valid=1, Out_code=0, Out_len=0.
  - Back-to-back requests give one result per cycle. Out_valid is a pulse with no backpressure.
  - Cfg_go=1 -> LOAD; table invalidated. A lookup accepted on that same cycle still returns its result.
- ERROR: Err holds its value. Cfg_go=1 -> LOAD.
- Cfg_go is ignored in LOAD, BUILD and CODE.
- Abort=1, any state: IDLE on the next edge. Clears Table_valid, Busy, Err, Enc_ready and pending Out_valid. Frequencies and table contents are kept but unusable.
- Abort and Cfg_go on the same cycle: Abort wins.
- Build_done / Code_done outside their own state: ignored.
- Busy = (state is LOAD, BUILD or CODE). Build_start, Start_code and Out_valid are registered outputs.
- Timeout counter width: ceil(log2(TIMEOUT+1)); saturates, never wraps.

Test Plan:
- Nominal flow:
  - Stimulus: frequencies 5,9,12,13,16,45,1,2,3,4; Build_done 3 cycles after Build_start; Code_done 6 cycles after Start_code, with Code_bus entry0={4'd3,9'h005}.
  - Required response: Build_start and Start_code one cycle each; Table_valid=1; lookup sym 0 -> Out_valid next cycle, Out_len=3, Out_code=0x005.
- Handshake gaps: Freq_valid toggled every other cycle during LOAD -> Freq_bus equals the 10 values in order; BUILD entered only after the 10th handshake.
- Timeouts:
  - Build_done never asserted -> Err=01 exactly TIMEOUT cycles after Build_start; Busy=0.
  - Cfg_go then restarts LOAD with Err=00.
  - Same check for Code_done -> Err=10.
- All-zero frequencies: 10 zeros loaded -> ERROR, Err=11; Build_start never pulses.
- Lookup edges in READY:
  - Back-to-back syms 9,3,12 -> three consecutive Out_valid pulses; sym 12 gives Out_len=0, Out_code=0.
  - Cfg_go with a simultaneous lookup -> result still returned, Table_valid=0 next cycle.
- Abort and reset:
  - Abort mid-BUILD -> IDLE next edge; a later Build_done is ignored.
  - Abort+Cfg_go on the same cycle -> IDLE.
  - n_Rst pulsed mid-CODE -> all outputs 0 immediately.
